// File: rtl/sccb_reg_responder.sv
// sccb_reg_responder: camera-side SCCB/I2C responder that exposes OV5640-style
// 16-bit-address / 8-bit-data register accesses on a simple register-file port.
// SCL/SDA are oversampled on clk; all bus timing is derived from detected edges.
// Optional feature macro: SCCB_RESP_AUTOINC_EN. When defined, the register
// pointer advances after every write byte and every master-ACKed read byte.
// When undefined, the pointer stays at the address loaded by ADDR_L.

module sccb_reg_responder #(
  parameter logic [7:0] DEVICE_ID   = 8'h78,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  output logic        reg_wr_en,
  output logic [15:0] reg_wr_addr,
  output logic [7:0]  reg_wr_data,
  output logic        reg_rd_req,
  output logic [15:0] reg_rd_addr,
  input  logic [7:0]  reg_rd_data,
  output logic        busy
);

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_ID         = 4'd1;
  localparam logic [3:0] S_ID_ACK     = 4'd2;
  localparam logic [3:0] S_ADDR_H     = 4'd3;
  localparam logic [3:0] S_ADDR_H_ACK = 4'd4;
  localparam logic [3:0] S_ADDR_L     = 4'd5;
  localparam logic [3:0] S_ADDR_L_ACK = 4'd6;
  localparam logic [3:0] S_WDATA      = 4'd7;
  localparam logic [3:0] S_WDATA_ACK  = 4'd8;
  localparam logic [3:0] S_RDATA      = 4'd9;
  localparam logic [3:0] S_RDATA_ACK  = 4'd10;
  localparam logic [3:0] S_IGNORE     = 4'd11;

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl_s;
  logic                   sda_s;
  logic                   scl_rise;
  logic                   scl_fall;
  logic                   start_det;
  logic                   stop_det;

  logic [3:0]  state;
  logic [2:0]  bit_cnt;
  logic [6:0]  shift_reg;
  logic [7:0]  rx_byte;
  logic [7:0]  tx_reg;
  logic [15:0] pointer;
  logic        ack_phase;
  logic        rd_mode;
  logic        rd_capture;

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];

  // START wins over a simultaneous SCL rise because only the level of SCL matters here
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & sda_d & ~sda_s;
  assign stop_det  = scl_s & ~sda_d & sda_s;

  assign rx_byte = {shift_reg, sda_s};

  // Synchronize the bus pins and keep one extra stage for edge detection; idle bus is high
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  // Transaction decoder: bytes shift in on SCL rise, SDA drive only moves on SCL fall
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      bit_cnt     <= 3'd0;
      shift_reg   <= 7'd0;
      tx_reg      <= 8'd0;
      pointer     <= 16'd0;
      ack_phase   <= 1'b0;
      rd_mode     <= 1'b0;
      rd_capture  <= 1'b0;
      sda_oe      <= 1'b0;
      reg_wr_en   <= 1'b0;
      reg_wr_addr <= 16'd0;
      reg_wr_data <= 8'd0;
      reg_rd_req  <= 1'b0;
      reg_rd_addr <= 16'd0;
      busy        <= 1'b0;
    end else begin
      reg_wr_en  <= 1'b0;
      reg_rd_req <= 1'b0;
      rd_capture <= reg_rd_req;
      if (rd_capture) begin
        tx_reg <= reg_rd_data;
      end

      if (start_det) begin
        state     <= S_ID;
        bit_cnt   <= 3'd0;
        ack_phase <= 1'b0;
        sda_oe    <= 1'b0;
        busy      <= 1'b1;
      end else if (stop_det) begin
        state     <= S_IDLE;
        ack_phase <= 1'b0;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          S_ID, S_ADDR_H, S_ADDR_L, S_WDATA: begin
            if (scl_rise) begin
              shift_reg <= rx_byte[6:0];
              bit_cnt   <= bit_cnt + 3'd1;
              ack_phase <= 1'b0;
              if (bit_cnt == 3'd7) begin
                case (state)
                  S_ID: begin
                    if (rx_byte[7:1] == DEVICE_ID[7:1]) begin
                      rd_mode <= rx_byte[0];
                      state   <= S_ID_ACK;
                    end else begin
                      state <= S_IGNORE;
                    end
                  end
                  S_ADDR_H: begin
                    pointer[15:8] <= rx_byte;
                    state         <= S_ADDR_H_ACK;
                  end
                  S_ADDR_L: begin
                    pointer[7:0] <= rx_byte;
                    state        <= S_ADDR_L_ACK;
                  end
                  default: begin
                    reg_wr_en   <= 1'b1;
                    reg_wr_addr <= pointer;
                    reg_wr_data <= rx_byte;
`ifdef SCCB_RESP_AUTOINC_EN
                    pointer <= pointer + 16'd1;
`else
                    pointer <= pointer;
`endif
                    state <= S_WDATA_ACK;
                  end
                endcase
              end
            end
          end

          S_ID_ACK, S_ADDR_H_ACK, S_ADDR_L_ACK, S_WDATA_ACK: begin
            if (scl_rise && ack_phase && state == S_ID_ACK && rd_mode) begin
              reg_rd_req  <= 1'b1;
              reg_rd_addr <= pointer;
            end
            if (scl_fall) begin
              if (!ack_phase) begin
                sda_oe    <= 1'b1;
                ack_phase <= 1'b1;
              end else begin
                ack_phase <= 1'b0;
                bit_cnt   <= 3'd0;
                sda_oe    <= 1'b0;
                case (state)
                  S_ID_ACK: begin
                    if (rd_mode) begin
                      state  <= S_RDATA;
                      sda_oe <= ~tx_reg[7];
                      tx_reg <= {tx_reg[6:0], 1'b0};
                    end else begin
                      state <= S_ADDR_H;
                    end
                  end
                  S_ADDR_H_ACK: state <= S_ADDR_L;
                  default:      state <= S_WDATA;
                endcase
              end
            end
          end

          S_RDATA: begin
            if (scl_fall) begin
              sda_oe <= ~tx_reg[7];
              tx_reg <= {tx_reg[6:0], 1'b0};
            end else if (scl_rise) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state     <= S_RDATA_ACK;
                ack_phase <= 1'b0;
              end
            end
          end

          S_RDATA_ACK: begin
            if (scl_fall && !ack_phase) begin
              sda_oe    <= 1'b0;
              ack_phase <= 1'b1;
            end else if (scl_rise && ack_phase) begin
              ack_phase <= 1'b0;
              if (!sda_s) begin
                reg_rd_req <= 1'b1;
                bit_cnt    <= 3'd0;
                state      <= S_RDATA;
`ifdef SCCB_RESP_AUTOINC_EN
                pointer     <= pointer + 16'd1;
                reg_rd_addr <= pointer + 16'd1;
`else
                reg_rd_addr <= pointer;
`endif
              end else begin
                state <= S_IGNORE;
              end
            end
          end

          S_IDLE, S_IGNORE: begin
            sda_oe <= 1'b0;
          end

          default: begin
            state  <= S_IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
